// File: rtl/mem_access.sv
// Memory-access stage: launches one aligned load/store on the request/response bus
// and hands the registered result to the write stage.
package mem_access_pkg;
    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_lb;
        logic is_lh;
        logic is_lw;
        logic is_lbu;
        logic is_lhu;
        logic is_sb;
        logic is_sh;
        logic is_sw;
    } instructions;
endpackage

// state | meaning
// IDLE  | waiting for enabled; completed high
// REQ   | bus request held until mem_req_ready
// WAIT  | load issued, waiting for mem_rsp_valid
// DONE  | one-cycle write_enabled pulse
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enabled,
    input  instructions           instr,
    input  logic [31:0]           arith_result,
    input  logic [31:0]           rs2_data,
    input  logic                  is_jump_chosen,
    input  logic [31:0]           next_pc,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [BUS_ADDR_W-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rdata,
    output instructions           instr_n,
    output logic [31:0]           data_n,
    output logic                  is_jump_chosen_n,
    output logic [31:0]           next_pc_n,
    output logic                  write_enabled,
    output logic                  completed,
    output logic                  misaligned
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        mis_q;
    logic [1:0]  lane;
    logic        start;
    logic        mem_op;
    logic        mis_now;
    logic [31:0] rsh;
    logic [31:0] load_val;

    assign start   = (state == IDLE) && enabled;
    assign mem_op  = instr.is_load | instr.is_store;
    assign mis_now = ((instr.is_lh | instr.is_lhu | instr.is_sh) & arith_result[0])
                   | ((instr.is_lw | instr.is_sw) & (arith_result[1:0] != 2'b00));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (enabled) state_nx = (mem_op && !mis_now) ? REQ : DONE;
            REQ:  if (mem_req_ready) state_nx = instr_n.is_store ? DONE : WAIT;
            WAIT: if (mem_rsp_valid) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign mem_req_valid = (state == REQ);
    assign write_enabled = (state == DONE);
    assign misaligned    = write_enabled & mis_q;

    assign lane     = addr_q[1:0];
    assign mem_addr = BUS_ADDR_W'({addr_q[31:2], 2'b00});
    assign mem_we   = instr_n.is_store;
    assign rsh      = mem_rdata >> {lane, 3'b000};

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = wdata_q;
        if (instr_n.is_sb) begin
            mem_wstrb = 4'b0001 << lane;
            mem_wdata = {4{wdata_q[7:0]}};
        end else if (instr_n.is_sh) begin
            mem_wstrb = 4'b0011 << lane;
            mem_wdata = {2{wdata_q[15:0]}};
        end else if (instr_n.is_sw) begin
            mem_wstrb = 4'b1111;
        end
    end

    always_comb begin
        load_val = mem_rdata;
        if (instr_n.is_lb)       load_val = {{24{rsh[7]}}, rsh[7:0]};
        else if (instr_n.is_lbu) load_val = {24'h0, rsh[7:0]};
        else if (instr_n.is_lh)  load_val = {{16{rsh[15]}}, rsh[15:0]};
        else if (instr_n.is_lhu) load_val = {16'h0, rsh[15:0]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            completed        <= 1'b0;
            instr_n          <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            mis_q            <= 1'b0;
            data_n           <= '0;
            is_jump_chosen_n <= 1'b0;
            next_pc_n        <= '0;
        end else begin
            state     <= state_nx;
            completed <= (state_nx == IDLE);
            if (start) begin
                instr_n          <= instr;
                addr_q           <= arith_result;
                wdata_q          <= rs2_data;
                is_jump_chosen_n <= is_jump_chosen;
                next_pc_n        <= next_pc;
                mis_q            <= mem_op & mis_now;
                if (!mem_op)
                    data_n <= arith_result;
                else if (mis_now)
                    data_n <= '0;
            end
            // response only counts once the request has been accepted
            if (state == WAIT && mem_rsp_valid)
                data_n <= load_val;
        end
    end
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access with an arithmetic reference model of each access.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enabled = 1'b0;
    instructions instr = '0;
    logic [31:0] arith_result = '0;
    logic [31:0] rs2_data = '0;
    logic        is_jump_chosen = 1'b0;
    logic [31:0] next_pc = '0;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req_valid, mem_we, is_jump_chosen_n, write_enabled, completed, misaligned;
    logic [31:0] mem_addr, mem_wdata, data_n, next_pc_n;
    logic [3:0]  mem_wstrb;
    instructions instr_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access #(.BUS_ADDR_W(32)) dut (
        .clk(clk), .rstn(rstn), .enabled(enabled), .instr(instr),
        .arith_result(arith_result), .rs2_data(rs2_data),
        .is_jump_chosen(is_jump_chosen), .next_pc(next_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .instr_n(instr_n), .data_n(data_n), .is_jump_chosen_n(is_jump_chosen_n),
        .next_pc_n(next_pc_n), .write_enabled(write_enabled), .completed(completed),
        .misaligned(misaligned)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // kind: 0 add, 1 lb, 2 lh, 3 lw, 4 lbu, 5 lhu, 6 sb, 7 sh, 8 sw
    function automatic instructions decode(input int kind);
        instructions i;
        i = '0;
        i.is_load  = (kind >= 1 && kind <= 5);
        i.is_store = (kind >= 6);
        i.is_lb  = (kind == 1);
        i.is_lh  = (kind == 2);
        i.is_lw  = (kind == 3);
        i.is_lbu = (kind == 4);
        i.is_lhu = (kind == 5);
        i.is_sb  = (kind == 6);
        i.is_sh  = (kind == 7);
        i.is_sw  = (kind == 8);
        return i;
    endfunction

    function automatic int size_of(input int kind);
        if (kind == 1 || kind == 4 || kind == 6) return 1;
        if (kind == 2 || kind == 5 || kind == 7) return 2;
        return 4;
    endfunction

    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] rdata, input int stall, input int delay, input bit poke);
        instructions ei;
        int          sz, a, lat, c;
        bit          ld, st, mis, bus, done;
        logic [31:0] b, h, exp_data, exp_strb, exp_wdata, exp_addr, pc;
        logic        jmp;
        ei  = decode(kind);
        sz  = size_of(kind);
        ld  = (kind >= 1 && kind <= 5);
        st  = (kind >= 6);
        a   = int'(addr % 4);
        mis = (ld || st) && (a % sz != 0);
        bus = (ld || st) && !mis;
        b   = (rdata >> (8 * a)) % 256;
        h   = (rdata >> (8 * a)) % 65536;
        exp_addr = addr - 32'(a);
        if (!ld && !st)  exp_data = addr;
        else if (mis)    exp_data = 0;
        else if (kind == 1) exp_data = (b >= 128) ? b - 256 : b;
        else if (kind == 2) exp_data = (h >= 32768) ? h - 65536 : h;
        else if (kind == 3) exp_data = rdata;
        else if (kind == 4) exp_data = b;
        else                exp_data = h;
        if (!st)          exp_strb = 0;
        else if (sz == 1) exp_strb = 32'(1 << a);
        else if (sz == 2) exp_strb = 32'(3 * (1 << a));
        else              exp_strb = 15;
        if (sz == 1)      exp_wdata = (rs2 % 256) * 32'h0101_0101;
        else if (sz == 2) exp_wdata = (rs2 % 65536) * 32'h0001_0001;
        else              exp_wdata = rs2;
        lat = !bus ? 1 : (st ? 2 + stall : 3 + stall + delay);
        pc  = $urandom;
        jmp = 1'($urandom % 2);

        @(negedge clk);
        check_val("idle_completed", 32'(completed), 1);
        enabled = 1'b1; instr = ei; arith_result = addr; rs2_data = rs2;
        next_pc = pc; is_jump_chosen = jmp;
        @(negedge clk);
        enabled = 1'b0; instr = decode($urandom_range(0, 8)); arith_result = $urandom;
        rs2_data = $urandom; next_pc = $urandom; is_jump_chosen = ~jmp;
        check_val("completed_fall", 32'(completed), 0);
        c = 1;
        done = 1'b0;
        while (!done && c <= 60) begin
            enabled = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            check_val("req_valid", 32'(mem_req_valid), 32'(bus && c <= 1 + stall));
            if (mem_req_valid) begin
                check_val("mem_addr", mem_addr, exp_addr);
                check_val("mem_we", 32'(mem_we), 32'(st));
                check_val("mem_wstrb", 32'(mem_wstrb), exp_strb);
                if (st) check_val("mem_wdata", mem_wdata, exp_wdata);
            end
            if (bus && c == 1 + stall) begin
                mem_req_ready = 1'b1;
                if (ld) mem_rsp_valid = 1'b1;   // stray response in the handshake cycle
            end
            if (ld && bus && c == 2 + stall + delay) begin
                mem_rsp_valid = 1'b1;
                mem_rdata = rdata;
            end
            if (poke && ld && bus && c == 2 + stall) begin
                enabled = 1'b1; instr = decode(0); arith_result = $urandom; next_pc = $urandom;
            end
            if (write_enabled) begin
                done = 1'b1;
                check_val("latency", 32'(c), 32'(lat));
                if (!st) check_val("data_n", data_n, exp_data);
                check_val("misaligned", 32'(misaligned), 32'(mis));
                check_val("instr_n", 32'(instr_n), 32'(ei));
                check_val("next_pc_n", next_pc_n, pc);
                check_val("jump_n", 32'(is_jump_chosen_n), 32'(jmp));
            end else begin
                check_val("mis_quiet", 32'(misaligned), 0);
            end
            @(negedge clk);
            c++;
        end
        check_val("we_seen", 32'(done), 1);
        enabled = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        check_val("we_single", 32'(write_enabled), 0);
        check_val("completed_back", 32'(completed), 1);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        enabled = 1'b1; instr = decode(3); arith_result = 32'h300; next_pc = 32'h55;
        is_jump_chosen = 1'b1;
        @(negedge clk);
        enabled = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check_val("wait_no_req", 32'(mem_req_valid), 0);
        rstn = 1'b0;
        #1;
        check_val("rst_completed", 32'(completed), 0);
        check_val("rst_we", 32'(write_enabled), 0);
        check_val("rst_req", 32'(mem_req_valid), 0);
        check_val("rst_data_n", data_n, 0);
        check_val("rst_next_pc_n", next_pc_n, 0);
        check_val("rst_jump_n", 32'(is_jump_chosen_n), 0);
        @(negedge clk);
        rstn = 1'b1; mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check_val("rst_completed_up", 32'(completed), 1);
        for (int i = 0; i < 3; i++) begin
            check_val("rst_no_we", 32'(write_enabled), 0);
            check_val("rst_data_kept", data_n, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_val("init_completed", 32'(completed), 0);
        check_val("init_req", 32'(mem_req_valid), 0);
        check_val("init_we", 32'(write_enabled), 0);
        check_val("init_mis", 32'(misaligned), 0);
        check_val("init_data_n", data_n, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("first_completed", 32'(completed), 1);

        run_op(0, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 1'b0);
        run_op(1, 32'h0000_0103, 32'h0, 32'h80FF_FF00, 0, 0, 1'b0);
        run_op(7, 32'h0000_0202, 32'hABCD_5678, 32'h0, 3, 0, 1'b0);
        run_op(3, 32'h0000_0101, 32'h0, 32'h0, 0, 0, 1'b0);
        run_op(3, 32'h0000_0400, 32'h0, 32'h1357_9BDF, 1, 2, 1'b1);
        reset_in_wait();

        for (int n = 0; n < 150; n++) begin
            run_op($urandom_range(0, 8), $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), ($urandom % 4) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: BUS_ADDR_W, 32, width of mem_addr in bits.
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous and active-low.
REQ-004 Port: enabled  input  1  one-cycle start pulse from execute.
REQ-005 Port: instr  input  instructions  decoded instruction; uses is_load, is_store, is_lb/lh/lw/lbu/lhu, is_sb/sh/sw.
REQ-006 Port: arith_result  input  32  ALU result; the effective address for loads/stores.
REQ-007 Port: rs2_data  input  32  store data.
REQ-008 Port: is_jump_chosen / next_pc  input  1 / 32  branch outcome, passed through.
REQ-009 Port: mem_req_valid / mem_req_ready  output / input  1 / 1  bus request handshake.
REQ-010 Port: mem_addr / mem_we / mem_wstrb / mem_wdata  output  BUS_ADDR_W / 1 / 4 / 32  request payload; address word-aligned (bits [1:0]=0).
REQ-011 Port: mem_rsp_valid / mem_rdata  input  1 / 32  load response.
REQ-012 Port: instr_n / data_n / is_jump_chosen_n / next_pc_n  output  instructions / 32 / 1 / 32  registered results for the write stage.
REQ-013 Port: write_enabled  output  1  one-cycle pulse launching the write stage.
REQ-014 Port: completed  output  1  high when idle and ready for a new enabled.
REQ-015 Port: misaligned  output  1  one-cycle pulse on a misaligned access.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE; reset state IDLE.
REQ-017 IDLE + enabled: capture instr, arith_result, rs2_data, is_jump_chosen, next_pc; completed falls next cycle.
REQ-018 Non-memory instruction: IDLE -> DONE; data_n <= arith_result.
REQ-019 Misaligned access (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0): IDLE -> DONE, no bus request, data_n <= 0, misaligned pulses with write_enabled.
REQ-020 Aligned load/store: IDLE -> REQ; mem_req_valid held high in REQ with stable payload until mem_req_ready.
REQ-021 Store: wstrb = 0001<<a for sb, 0011<<a for sh, 1111 for sw (a = addr[1:0]); wdata = byte replicated x4 / half x2 / word; mem_we=1; REQ -> DONE on handshake (posted, no response).
REQ-022 Load: mem_we=0, wstrb=0000; REQ -> WAIT on handshake; WAIT -> DONE on mem_rsp_valid.
REQ-023 Load data: lane selected by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unchanged; result in data_n.
REQ-024 mem_rsp_valid is sampled only in WAIT; ignored in every other state, including the handshake cycle.
REQ-025 DONE lasts one cycle: write_enabled=1, then -> IDLE with completed=1.
REQ-026 Minimum latency enabled -> write_enabled: 1 cycle for non-memory/misaligned, 2 + bus stall cycles for stores, 3 + stalls for loads.
REQ-027 enabled outside IDLE is ignored; captured operands are not modified.
REQ-028 instr_n, is_jump_chosen_n, next_pc_n equal captured values while write_enabled is high.

Reset
REQ-029 rstn low asynchronously forces IDLE, mem_req_valid=0, write_enabled=0, misaligned=0, completed=0, data_n=0, next_pc_n=0, is_jump_chosen_n=0.
REQ-030 First rising clk edge with rstn high sets completed=1.
REQ-031 Reset during REQ or WAIT abandons the access; a later stray mem_rsp_valid has no effect.

Verification
REQ-032 add, arith_result=0x1234 -> write_enabled one cycle after enabled, data_n=0x1234, no bus request.
REQ-033 lb at addr 0x103, mem_rdata=0x80FF_FF00, ready immediate -> mem_addr=0x100, data_n=0xFFFF_FF80.
REQ-034 sh at 0x202, rs2_data=0xABCD_5678, ready stalled 3 cycles -> payload stable, wstrb=1100, wdata=0x5678_5678, write_enabled 1 cycle after handshake.
REQ-035 lw at 0x101 -> no mem_req_valid, misaligned and write_enabled pulse together, data_n=0.
REQ-036 rstn low in WAIT, then mem_rsp_valid -> IDLE, no write_enabled; completed=1 one cycle after rstn high.
REQ-037 enabled asserted in WAIT -> ignored; single write_enabled, original data_n.
